if_id_skid_stage: RTL and testbench

//  Parametrised IF/ID pipeline stage. Registers instruction and PC+4 from fetch.

---
 rtl/if_id_skid_stage.sv | 137 +++++++++++++
 tb/tb_if_id_skid_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_stage.sv
// if_id_skid_stage: IF/ID pipeline register with valid/ready handshake and a
// one-entry skid buffer so decode back-pressure never drops or duplicates a
// fetched word. In_Flush squashes every held and incoming word.
// Optional feature: define IFID_PREV_PC_EN to add Out_PrevPCAdder, which holds
// the PC+4 of the word that the current main-slot word replaced.
`timescale 1ns/1ps

module if_id_skid_stage #(
    parameter int                   INSTR_W   = 32,
    parameter int                   PC_W      = 32,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = {INSTR_W{1'b0}}
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    input  logic                    In_Valid,
    output logic                    Out_Ready,
    input  logic [INSTR_W-1:0]      In_Instruction,
    input  logic [PC_W-1:0]         In_PCAdder,
    input  logic                    In_Flush,
    output logic                    Out_Valid,
    input  logic                    In_Ready,
    output logic [INSTR_W-1:0]      Out_Instruction,
    output logic [PC_W-1:0]         Out_PCAdder
`ifdef IFID_PREV_PC_EN
    ,
    output logic [PC_W-1:0]         Out_PrevPCAdder
`endif
);

    // Main slot: the word currently presented to decode.
    logic                   out_valid_q, out_valid_d;
    logic [INSTR_W-1:0]     out_instr_q, out_instr_d;
    logic [PC_W-1:0]        out_pc_q,    out_pc_d;

    // Skid slot: absorbs the one word fetch sent before it saw back-pressure.
    logic                   skid_full_q, skid_full_d;
    logic [INSTR_W-1:0]     skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]        skid_pc_q,    skid_pc_d;

    logic                   accept_s;
    logic                   main_load_s;

    // Out_Ready depends only on the skid register, so In_Ready never reaches it combinationally.
    assign accept_s    = In_Valid & ~skid_full_q;
    assign main_load_s = ~out_valid_q | In_Ready;

    // Next-state for both slots: flush first, then main refill (skid before input), else skid capture.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        skid_full_d  = skid_full_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (In_Flush) begin
            // Squash everything; PC+4 is left as-is, instruction becomes a NOP.
            out_valid_d = 1'b0;
            skid_full_d = 1'b0;
            out_instr_d = NOP_INSTR;
        end else if (main_load_s) begin
            if (skid_full_q) begin
                // Older word waiting in the skid goes first to keep FIFO order.
                out_valid_d = 1'b1;
                out_instr_d = skid_instr_q;
                out_pc_d    = skid_pc_q;
                skid_full_d = 1'b0;
            end else if (accept_s) begin
                out_valid_d = 1'b1;
                out_instr_d = In_Instruction;
                out_pc_d    = In_PCAdder;
            end else begin
                // Nothing to present; data holds its last value.
                out_valid_d = 1'b0;
            end
        end else if (accept_s) begin
            // Main is stalled with a live word: park the incoming word in the skid.
            skid_full_d  = 1'b1;
            skid_instr_d = In_Instruction;
            skid_pc_d    = In_PCAdder;
        end else begin
            skid_full_d = skid_full_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            out_valid_q  <= 1'b0;
            out_instr_q  <= NOP_INSTR;
            out_pc_q     <= {PC_W{1'b0}};
            skid_full_q  <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= {PC_W{1'b0}};
        end else begin
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            skid_full_q  <= skid_full_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

`ifdef IFID_PREV_PC_EN
    logic [PC_W-1:0]        prev_pc_q, prev_pc_d;
    logic                   new_word_s;

    assign new_word_s = ~In_Flush & main_load_s & (skid_full_q | accept_s);

    // Remember the PC+4 being replaced whenever the main slot takes a new word.
    always_comb begin
        prev_pc_d = prev_pc_q;
        if (new_word_s) begin
            prev_pc_d = out_pc_q;
        end else begin
            prev_pc_d = prev_pc_q;
        end
    end

    // Previous-PC register; cleared by reset only, untouched by flush.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            prev_pc_q <= {PC_W{1'b0}};
        end else begin
            prev_pc_q <= prev_pc_d;
        end
    end

    assign Out_PrevPCAdder = prev_pc_q;
`endif

    assign Out_Ready       = ~skid_full_q;
    assign Out_Valid       = out_valid_q;
    assign Out_Instruction = out_instr_q;
    assign Out_PCAdder     = out_pc_q;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Testbench for if_id_skid_stage: directed vectors plus a short random phase.
// The driver pushes each word it expects to be accepted into exp_q; a separate
// monitor compares and pops on every consume. Flush or reset empties exp_q.
`timescale 1ns/1ps

module tb_if_id_skid_stage;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        In_Valid;
    logic        Out_Ready;
    logic [31:0] In_Instruction;
    logic [31:0] In_PCAdder;
    logic        In_Flush;
    logic        Out_Valid;
    logic        In_Ready;
    logic [31:0] Out_Instruction;
    logic [31:0] Out_PCAdder;
`ifdef IFID_PREV_PC_EN
    logic [31:0] Out_PrevPCAdder;
`endif

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    if_id_skid_stage dut (
        .Clock           (Clock),
        .Reset_n         (Reset_n),
        .In_Valid        (In_Valid),
        .Out_Ready       (Out_Ready),
        .In_Instruction  (In_Instruction),
        .In_PCAdder      (In_PCAdder),
        .In_Flush        (In_Flush),
        .Out_Valid       (Out_Valid),
        .In_Ready        (In_Ready),
        .Out_Instruction (Out_Instruction),
        .Out_PCAdder     (Out_PCAdder)
`ifdef IFID_PREV_PC_EN
        ,
        .Out_PrevPCAdder (Out_PrevPCAdder)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; model update happens after the edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl);
        logic acc;
        In_Valid       = v;
        In_Instruction = ins;
        In_PCAdder     = pc;
        In_Ready       = rdy;
        In_Flush       = fl;
        acc = v && (exp_q.size() < 2);
        @(posedge Clock);
        #1;
        if (!Reset_n || fl) exp_q.delete();
        else if (acc) exp_q.push_back({ins, pc});
    endtask

    // Monitor: mid-cycle compare of handshake and presented word against the model.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge Clock);
            if (Reset_n === 1'b1) begin
                chk("out_ready", {31'd0, Out_Ready}, {31'd0, (exp_q.size() < 2)});
                chk("out_valid", {31'd0, Out_Valid}, {31'd0, (exp_q.size() > 0)});
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    chk("out_instr", Out_Instruction, e[63:32]);
                    chk("out_pc",    Out_PCAdder,     e[31:0]);
                    if (In_Ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        Reset_n = 1'b0;
        In_Valid = 1'b0; In_Instruction = 32'd0; In_PCAdder = 32'd0;
        In_Ready = 1'b0; In_Flush = 1'b0;

        // 1 Reset with In_Valid asserted
        step(1'b1, 32'hDEADBEEF, 32'd100, 1'b1, 1'b0);
        step(1'b1, 32'hDEADBEEF, 32'd104, 1'b1, 1'b0);
        chk("rst_valid", {31'd0, Out_Valid}, 32'd0);
        chk("rst_instr", Out_Instruction, 32'd0);
        chk("rst_pc",    Out_PCAdder,     32'd0);
        chk("rst_ready", {31'd0, Out_Ready}, 32'd1);
`ifdef IFID_PREV_PC_EN
        chk("rst_prev", Out_PrevPCAdder, 32'd0);
`endif
        Reset_n = 1'b1;

        // 2 Stream (also 6: previous PC)
        step(1'b1, 32'h20080005, 32'd4, 1'b1, 1'b0);
        chk("strm_pc0", Out_PCAdder, 32'd4);
`ifdef IFID_PREV_PC_EN
        chk("prev0", Out_PrevPCAdder, 32'd0);
`endif
        step(1'b1, 32'h20090007, 32'd8, 1'b1, 1'b0);
        chk("strm_pc1", Out_PCAdder, 32'd8);
`ifdef IFID_PREV_PC_EN
        chk("prev1", Out_PrevPCAdder, 32'd4);
`endif
        step(1'b1, 32'h01095020, 32'd12, 1'b1, 1'b0);
        chk("strm_instr2", Out_Instruction, 32'h01095020);
`ifdef IFID_PREV_PC_EN
        chk("prev2", Out_PrevPCAdder, 32'd8);
`endif
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // 3 Stall: A held, B absorbed into skid
        step(1'b1, 32'h8C080000, 32'd16, 1'b1, 1'b0);
        step(1'b1, 32'hAC080004, 32'd20, 1'b0, 1'b0);
        chk("stall_ready", {31'd0, Out_Ready}, 32'd0);
        chk("stall_a", Out_Instruction, 32'h8C080000);
        step(1'b1, 32'h11111111, 32'd99, 1'b0, 1'b0);
        chk("stall_hold", Out_PCAdder, 32'd16);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("stall_b", Out_Instruction, 32'hAC080004);
        chk("stall_ready1", {31'd0, Out_Ready}, 32'd1);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // 4 Flush with skid full
        step(1'b1, 32'h22222222, 32'd24, 1'b1, 1'b0);
        step(1'b1, 32'h33333333, 32'd28, 1'b0, 1'b0);
        step(1'b1, 32'h44444444, 32'd32, 1'b0, 1'b1);
        chk("fl_valid", {31'd0, Out_Valid}, 32'd0);
        chk("fl_instr", Out_Instruction, 32'd0);
        chk("fl_pc",    Out_PCAdder,     32'd24);
        chk("fl_ready", {31'd0, Out_Ready}, 32'd1);
        // Flush while a word is accepted in the same cycle
        step(1'b1, 32'h55555555, 32'd36, 1'b1, 1'b0);
        step(1'b1, 32'h66666666, 32'd40, 1'b0, 1'b1);
        chk("fl2_valid", {31'd0, Out_Valid}, 32'd0);
        chk("fl2_pc",    Out_PCAdder,     32'd36);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Reset in the middle of a stall
        step(1'b1, 32'h77777777, 32'd44, 1'b1, 1'b0);
        step(1'b1, 32'h88888888, 32'd48, 1'b0, 1'b0);
        Reset_n = 1'b0;
        step(1'b1, 32'h99999999, 32'd52, 1'b0, 1'b0);
        chk("mrst_valid", {31'd0, Out_Valid}, 32'd0);
        chk("mrst_ready", {31'd0, Out_Ready}, 32'd1);
        chk("mrst_pc",    Out_PCAdder,     32'd0);
        Reset_n = 1'b1;

        // 5 Random traffic against the scoreboard
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 32'(1000 + i * 4),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) < 2));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
